// File: rtl/fs4_serial_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default operand width.
package fs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FS_N_DEF = 4;

endpackage

// File: rtl/fs4_serial_fs.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module fs (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/fs4_serial.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock, computing {bo, d} = a - b - bi.
// Optional signed-overflow output enabled by defining FS4_SERIAL_OVF_EN.
module fs4_serial
  import fs_pkg::*;
#(
  parameter int N = FS_N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic [N-1:0] d,
  output logic         bo,
  output logic         busy,
  output logic         done
`ifdef FS4_SERIAL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_sh, b_sh, res, res_nxt;
  logic           brw;
  logic           dbit, bbit;
  logic           accept, last;
`ifdef FS4_SERIAL_OVF_EN
  logic           a_msb, b_msb;
`endif

  fs u_fs (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (brw),
    .d  (dbit),
    .bo (bbit)
  );

  // A start is honoured from IDLE and from DONE; while RUN it is dropped.
  assign accept  = start && (state != RUN);
  assign last    = (state == RUN) && (cnt == CW'(N - 1));
  assign res_nxt = {dbit, {(N-1){1'b0}}} | (res >> 1);
  assign busy    = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: FSM, bit counter, borrow flop and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
      done  <= 1'b0;
`ifdef FS4_SERIAL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      if (accept) begin
        cnt <= '0;
        brw <= bi;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        brw <= bbit;
      end
      // The result becomes visible only once the final bit has been formed.
      if (last) begin
        d  <= res_nxt;
        bo <= bbit;
`ifdef FS4_SERIAL_OVF_EN
        ovf <= (a_msb != b_msb) && (dbit != a_msb);
`endif
      end
    end
  end

  // Datapath: operand shifters and partial-result register.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
`ifdef FS4_SERIAL_OVF_EN
      a_msb <= a[N-1];
      b_msb <= b[N-1];
`endif
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= res_nxt;
    end
  end

endmodule

// File: tb/tb_fs4_serial.sv
// Bench for fs4_serial: directed and random subtractions against an arithmetic reference.
module tb_fs4_serial;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, start, bi, bo, busy, done;
  logic [N-1:0] a, b, d;
`ifdef FS4_SERIAL_OVF_EN
  logic         ovf;
`endif

  int           total = 0;
  int           bad   = 0;
  logic [N-1:0] exp_d;
  logic         exp_bo;
  logic [N-1:0] nxt_a, nxt_b;
  logic         nxt_c;

  always #5 clk = ~clk;

  fs4_serial #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .d     (d),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
`ifdef FS4_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {bo, d} as plain integer subtraction taken modulo 2^(N+1).
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return r[N:0];
  endfunction

  // Signed overflow: true signed difference of a and b falls outside the N-bit range.
  function automatic logic model_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    int sx, sy, df;
    sx = x[N-1] ? int'(x) - (1 << N) : int'(x);
    sy = y[N-1] ? int'(y) - (1 << N) : int'(y);
    df = sx - sy - int'(c);
    return (df > (1 << (N-1)) - 1) || (df < -(1 << (N-1)));
  endfunction

  task automatic scramble();
    a  = N'($urandom);
    b  = N'($urandom);
    bi = 1'($urandom);
  endtask

  // Called just after a falling edge. pre: start already accepted by the previous call's chain.
  task automatic do_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xc,
                       input bit pre, input bit poke, input bit chain);
    logic [N:0] r;
    int         k0;
    r = model(xa, xb, xc);
    if (!pre) begin
      a = xa; b = xb; bi = xc; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      scramble();
    end
    k0 = pre ? 2 : 1;
    for (int k = k0; k <= N + 2; k++) begin
      @(negedge clk);
      check("busy", busy, (k <= N) || (chain && k == N + 2));
      check("done", done, k == N + 2);
      if (k == N) begin
        check("d_hold", d, exp_d);
        check("bo_hold", bo, exp_bo);
      end
      if (k == N + 2) begin
        check("d", d, r[N-1:0]);
        check("bo", bo, r[N]);
`ifdef FS4_SERIAL_OVF_EN
        check("ovf", ovf, model_ovf(xa, xb, xc));
`endif
      end
      if (poke && k == 2) begin
        start = 1'b1; a = '1; b = '1; bi = 1'b0;
      end
      if (poke && k == 3) begin
        start = 1'b0;
        scramble();
      end
      if (chain && k == N + 1) begin
        start = 1'b1; a = nxt_a; b = nxt_b; bi = nxt_c;
      end
      if (chain && k == N + 2) begin
        start = 1'b0;
        scramble();
      end
    end
    exp_d  = r[N-1:0];
    exp_bo = r[N];
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    exp_d = '0; exp_bo = 1'b0;
    nxt_a = '0; nxt_b = '0; nxt_c = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_d", d, 0);
    check("rst_bo", bo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef FS4_SERIAL_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;

    do_op(4'h9, 4'h3, 1'b0, 0, 0, 0);
    do_op(4'h3, 4'h9, 1'b0, 0, 0, 0);
    do_op(4'h0, 4'h0, 1'b1, 0, 0, 0);
    do_op(4'h5, 4'h5, 1'b0, 0, 0, 0);
    do_op(4'h0, 4'hF, 1'b1, 0, 0, 0);
    do_op(4'h8, 4'h1, 1'b0, 0, 0, 0);
    do_op(4'h2, 4'h1, 1'b0, 0, 0, 0);

    // Ignored start during RUN, then a start in the DONE cycle.
    nxt_a = 4'hC; nxt_b = 4'h5; nxt_c = 1'b1;
    do_op(4'h5, 4'h1, 1'b0, 0, 1, 1);
    do_op(nxt_a, nxt_b, nxt_c, 1, 0, 0);

    // Reset in the second RUN cycle aborts the operation.
    a = 4'h9; b = 4'h3; bi = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", d, 0);
    check("abort_bo", bo, 0);
    exp_d = '0; exp_bo = 1'b0;
    rst = 1'b0;
    do_op(4'h7, 4'h2, 1'b0, 0, 0, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; a = 4'h6; b = 4'h1; bi = 1'b0;
    @(negedge clk);
    check("prio_busy", busy, 0);
    check("prio_d", d, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("prio_idle", busy, 0);
    exp_d = '0; exp_bo = 1'b0;

    for (int i = 0; i < 12; i++)
      do_op(N'($urandom), N'($urandom), 1'($urandom), 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
